// File: rtl/fix_convert_sched.sv
// ---------------------------------------------------------------------------
// fix_convert_sched
// Round-robin front end that shares a single float-to-fixed converter
// (fix_single_to_fix) among N_REQ requesters. One operand is granted,
// registered and converted, and the result is returned with the requester
// ID over a valid/ready handshake. Inf/NaN operands bypass the converter and
// force a saturated result.
//
// Optional build macro: FIX_SCHED_SIGNED_OUT_EN
//   undefined : out_data_o is the unsigned magnitude; sign bit ignored.
//   defined   : out_data_o is two's-complement, clamped to the signed range.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester request valid
//   req_data_i   packed singles, requester i at [32*i+31:32*i]
//   req_ready_o  one-hot accept strobe (IDLE only)
//   out_valid_o  result valid
//   out_ready_i  consumer ready
//   out_data_o   fixed-point result, W bits
//   out_id_o     index of the originating requester
//   out_sat_o    result saturated or forced
//   busy_o       FSM not in IDLE
// ---------------------------------------------------------------------------

// Shared converter: unsigned, truncating, saturating to all ones.
module fix_single_to_fix #(
   parameter int INT_WIDTH   = 12,
   parameter int FRACT_WIDTH = 4,
   localparam int W          = INT_WIDTH + FRACT_WIDTH
) (
   input  logic [30:0]  op_i,
   output logic [W-1:0] mag_o
);
   logic [7:0]        exp_w;
   logic [23:0]       man_w;
   logic signed [11:0] sh_w;
   logic [11:0]       rsh_w;
   logic [W+23:0]     ext_w;
   logic [W+23:0]     wide_w;
   logic              ovf_w;

   always_comb begin
      exp_w = op_i[30:23];
      // Zero/denormal: exponent behaves as 1 with the hidden bit clear.
      man_w = {(exp_w != 8'd0), op_i[22:0]};
      sh_w  = $signed({4'd0, (exp_w == 8'd0) ? 8'd1 : exp_w})
              - 12'sd150 + $signed(12'(FRACT_WIDTH));
      rsh_w = 12'(-sh_w);
      ext_w = {{W{1'b0}}, man_w};
      if (!sh_w[11]) wide_w = ext_w << $unsigned(sh_w);
      else           wide_w = ext_w >> rsh_w;
      // Shifts of W or more push every mantissa bit past the top; otherwise
      // the product fits the wide vector and its upper part flags overflow.
      if (!sh_w[11] && (sh_w >= $signed(12'(W)))) ovf_w = |man_w;
      else                                        ovf_w = |wide_w[W+23:W];
      mag_o = ovf_w ? {W{1'b1}} : wide_w[W-1:0];
   end
endmodule

module fix_convert_sched #(
   parameter int N_REQ       = 4,
   parameter int INT_WIDTH   = 12,
   parameter int FRACT_WIDTH = 4,
   localparam int W          = INT_WIDTH + FRACT_WIDTH,
   localparam int ID_W       = $clog2(N_REQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [N_REQ-1:0]     req_valid_i,
   input  logic [32*N_REQ-1:0]  req_data_i,
   output logic [N_REQ-1:0]     req_ready_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [W-1:0]         out_data_o,
   output logic [ID_W-1:0]      out_id_o,
   output logic                 out_sat_o,
   output logic                 busy_o
);
   typedef enum logic [1:0] {S_IDLE, S_CONV, S_HOLD} state_e;

   state_e                 state_q, state_d;
   logic [N_REQ-1:0][31:0] req_data_w;
   logic [ID_W-1:0]        last_grant_q;
   logic [ID_W-1:0]        grant_idx;
   logic                   grant_found;
   logic [31:0]            op_q;
   logic [ID_W-1:0]        id_q;
   logic [W-1:0]           out_data_q;
   logic [ID_W-1:0]        out_id_q;
   logic                   out_sat_q;
   logic                   out_valid_q;
   logic [W-1:0]           mag_w;
   logic [W-1:0]           res_data;
   logic                   res_sat;
   logic                   exp_ff;

   assign req_data_w = req_data_i;

   // Rotating priority search starting just after the last grant.
   always_comb begin
      int cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(last_grant_q) + k) % N_REQ;
         if (!grant_found && req_valid_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(cand);
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_found) state_d = S_CONV;
         S_CONV:  state_d = S_HOLD;
         S_HOLD:  if (out_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      req_ready_o = '0;
      if (state_q == S_IDLE && grant_found) req_ready_o[grant_idx] = 1'b1;
      busy_o = (state_q != S_IDLE);
   end

   fix_single_to_fix #(
      .INT_WIDTH   (INT_WIDTH),
      .FRACT_WIDTH (FRACT_WIDTH)
   ) u_conv (
      .op_i  (op_q[30:0]),
      .mag_o (mag_w)
   );

   assign exp_ff = &op_q[30:23];

`ifdef FIX_SCHED_SIGNED_OUT_EN
   localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   always_comb begin
      res_data = mag_w;
      res_sat  = 1'b0;
      if (exp_ff) begin
         // Only +Inf clamps positive; -Inf and every NaN clamp negative.
         res_data = (!op_q[31] && op_q[22:0] == 23'd0) ? MAX_POS : MIN_NEG;
         res_sat  = 1'b1;
      end else if (!op_q[31]) begin
         if (mag_w > MAX_POS) begin
            res_data = MAX_POS;
            res_sat  = 1'b1;
         end
      end else begin
         if (mag_w > MIN_NEG) begin
            res_data = MIN_NEG;
            res_sat  = 1'b1;
         end else begin
            res_data = '0 - mag_w;
         end
      end
   end
`else
   always_comb begin
      res_data = exp_ff ? {W{1'b1}} : mag_w;
      res_sat  = exp_ff | (&mag_w);
   end
`endif

   // Datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_grant_q <= ID_W'(N_REQ - 1);
         op_q         <= '0;
         id_q         <= '0;
         out_data_q   <= '0;
         out_id_q     <= '0;
         out_sat_q    <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (grant_found) begin
               op_q         <= req_data_w[grant_idx];
               id_q         <= grant_idx;
               last_grant_q <= grant_idx;
            end
            S_CONV: begin
               out_data_q  <= res_data;
               out_id_q    <= id_q;
               out_sat_q   <= res_sat;
               out_valid_q <= 1'b1;
            end
            S_HOLD: if (out_ready_i) out_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_id_o    = out_id_q;
   assign out_sat_o   = out_sat_q;
endmodule

// File: tb/tb_fix_convert_sched.sv
// ---------------------------------------------------------------------------
// tb_fix_convert_sched
// Self-checking bench for fix_convert_sched: table-driven single conversions,
// hand-written round-robin / backpressure / async-reset sequences, and a
// randomized phase checked against a real-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fix_convert_sched;
   localparam int N_REQ       = 4;
   localparam int INT_WIDTH   = 12;
   localparam int FRACT_WIDTH = 4;
   localparam int W           = INT_WIDTH + FRACT_WIDTH;
   localparam int ID_W        = $clog2(N_REQ);

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [N_REQ-1:0]       req_valid = '0;
   logic [N_REQ-1:0][31:0] rd = '0;
   logic [32*N_REQ-1:0]    req_data;
   logic [N_REQ-1:0]       req_ready;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [W-1:0]           out_data;
   logic [ID_W-1:0]        out_id;
   logic                   out_sat;
   logic                   busy;

   assign req_data = rd;

   fix_convert_sched #(
      .N_REQ(N_REQ), .INT_WIDTH(INT_WIDTH), .FRACT_WIDTH(FRACT_WIDTH)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_id_o(out_id), .out_sat_o(out_sat),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
      end
   endtask

   typedef struct {
      logic [31:0]  in;
      logic [W-1:0] d;
      logic         s;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic [31:0] in, input logic [W-1:0] d, input logic s);
      vec_t v;
      v.in = in; v.d = d; v.s = s;
      tbl.push_back(v);
   endfunction

   typedef struct {
      logic [W-1:0]    d;
      logic [ID_W-1:0] id;
      logic            s;
   } res_t;
   res_t exp_q[$];

   // Reference conversion from the numeric meaning of the single.
   function automatic void ref_conv(input logic [31:0] f, output logic [W-1:0] d, output logic s);
      int     e    = int'(f[30:23]);
      real    frac = real'(f[22:0]);
      real    v;
      longint m;
      longint maxu = (longint'(1) << W) - 1;
      longint half = longint'(1) << (W - 1);
      if (e == 0) v = frac / (2.0 ** 23) * (2.0 ** (-126));
      else        v = (1.0 + frac / (2.0 ** 23)) * (2.0 ** (e - 127));
      v = v * (2.0 ** FRACT_WIDTH);
      if (v >= 2.0 ** W) m = maxu;
      else               m = longint'($floor(v));
`ifdef FIX_SCHED_SIGNED_OUT_EN
      if (e == 255) begin
         d = (!f[31] && f[22:0] == 0) ? W'(half - 1) : W'(half);
         s = 1'b1;
      end else if (!f[31]) begin
         if (m > half - 1) begin d = W'(half - 1); s = 1'b1; end
         else              begin d = W'(m);        s = 1'b0; end
      end else begin
         if (m > half) begin d = W'(half); s = 1'b1; end
         else          begin d = W'((maxu + 1 - m) % (maxu + 1)); s = 1'b0; end
      end
`else
      if (e == 255) begin d = W'(maxu); s = 1'b1; end
      else          begin d = W'(m);    s = (m == maxu); end
`endif
   endfunction

   function automatic int rr_pick(input int last, input logic [N_REQ-1:0] v);
      for (int k = 1; k <= N_REQ; k++)
         if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
      return -1;
   endfunction

   function automatic int low_bit(input logic [N_REQ-1:0] v);
      for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] rand_float();
      logic [7:0] e;
      int r = int'($urandom_range(0, 15));
      if (r == 0)      e = 8'hFF;
      else if (r == 1) e = 8'h00;
      else             e = 8'($urandom_range(110, 150));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // One isolated request with exact latency and handshake checks.
   task automatic single(input int idx, input logic [31:0] val, input logic [W-1:0] ed,
                         input logic es, input string nm);
      @(negedge clk);
      rd[idx] = val; req_valid = '0; req_valid[idx] = 1'b1; out_ready = 1'b1;
      #1 chk({nm, " grant"}, 32'(req_ready), 32'(1 << idx));
      @(negedge clk);
      req_valid = '0;
      #1 chk({nm, " conv busy/valid"}, {30'd0, busy, out_valid}, 32'b10);
      chk({nm, " conv ready"}, 32'(req_ready), 0);
      @(negedge clk);
      #1 chk({nm, " valid"}, 32'(out_valid), 1);
      chk({nm, " data"}, 32'(out_data), 32'(ed));
      chk({nm, " id"}, 32'(out_id), idx);
      chk({nm, " sat"}, 32'(out_sat), 32'(es));
      @(negedge clk);
      #1 chk({nm, " idle"}, {30'd0, busy, out_valid}, 0);
   endtask

   initial begin
      int drop, gcnt, ocnt, acc, g, nres;
      logic [W-1:0] ed;
      logic es;
      res_t r;

`ifdef FIX_SCHED_SIGNED_OUT_EN
      add(32'h3FC00000, 16'h0018, 1'b0);  // 1.5
      add(32'hC0000000, 16'hFFE0, 1'b0);  // -2.0
      add(32'h49742400, 16'h7FFF, 1'b1);  // 1e6
      add(32'hC9742400, 16'h8000, 1'b1);  // -1e6
      add(32'h44FFFE00, 16'h7FFF, 1'b0);  // 2047.9375 exact max
      add(32'h45000000, 16'h7FFF, 1'b1);  // 2048.0 clamps
      add(32'hC5000000, 16'h8000, 1'b0);  // -2048.0 exact min
      add(32'h7F800000, 16'h7FFF, 1'b1);  // +Inf
      add(32'hFF800000, 16'h8000, 1'b1);  // -Inf
      add(32'h7FC00000, 16'h8000, 1'b1);  // NaN
      add(32'h80000000, 16'h0000, 1'b0);  // -0.0
      add(32'h00000001, 16'h0000, 1'b0);  // denormal
`else
      add(32'h3FC00000, 16'h0018, 1'b0);  // 1.5
      add(32'h40000000, 16'h0020, 1'b0);  // 2.0
      add(32'hC0000000, 16'h0020, 1'b0);  // -2.0, sign ignored
      add(32'h49742400, 16'hFFFF, 1'b1);  // 1e6
      add(32'h7F800000, 16'hFFFF, 1'b1);  // +Inf
      add(32'h7FC00000, 16'hFFFF, 1'b1);  // NaN
      add(32'h00000000, 16'h0000, 1'b0);  // +0.0
      add(32'h80000000, 16'h0000, 1'b0);  // -0.0
      add(32'h00000001, 16'h0000, 1'b0);  // denormal
      add(32'h3D800000, 16'h0001, 1'b0);  // 0.0625, one LSB
      add(32'h3CF5C28F, 16'h0000, 1'b0);  // ~0.03 truncates
      add(32'h457FF000, 16'hFFF0, 1'b0);  // 4095.0
      add(32'h457FFF80, 16'hFFFF, 1'b1);  // 4095.9375 hits all ones
      add(32'h45800000, 16'hFFFF, 1'b1);  // 4096.0 overflows
`endif

      // Reset state
      #1;
      chk("reset ready", 32'(req_ready), 0);
      chk("reset valid", 32'(out_valid), 0);
      chk("reset data", 32'(out_data), 0);
      chk("reset id", 32'(out_id), 0);
      chk("reset sat", 32'(out_sat), 0);
      chk("reset busy", 32'(busy), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Round robin after reset: 0,1,2,3 then wrap to 0..3 again
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) rd[i] = 32'h40000000;
      req_valid = '1; out_ready = 1'b1;
      drop = -1; gcnt = 0; ocnt = 0;
      for (int c = 0; c < 60 && ocnt < 2 * N_REQ; c++) begin
         if (c != 0) @(negedge clk);
         if (drop >= 0) begin req_valid[drop] = 1'b0; drop = -1; end
         if (gcnt == N_REQ && req_valid == '0) req_valid = '1;
         #1;
         if (req_ready != '0) begin
            chk("rr grant", 32'(req_ready), 32'(1 << (gcnt % N_REQ)));
            drop = low_bit(req_ready);
            gcnt++;
         end
         if (out_valid) begin
            chk("rr id", 32'(out_id), ocnt % N_REQ);
            chk("rr data", 32'(out_data), 32'h0020);
            ocnt++;
         end
      end
      chk("rr result count", ocnt, 2 * N_REQ);
      @(negedge clk); req_valid = '0;
      @(negedge clk);

      // Table of single conversions
      foreach (tbl[i]) single(i % N_REQ, tbl[i].in, tbl[i].d, tbl[i].s, $sformatf("vec%0d", i));

      // Backpressure with requester 1 pending
      @(negedge clk);
      rd[0] = 32'h3FC00000; req_valid = 4'b0001; out_ready = 1'b0;
      #1 chk("bp grant0", 32'(req_ready), 32'b0001);
      @(negedge clk);
      req_valid = 4'b0010; rd[1] = 32'h40000000;
      #1 chk("bp conv ready", 32'(req_ready), 0);
      @(negedge clk);
      #1 chk("bp valid", 32'(out_valid), 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1 chk("bp hold valid", 32'(out_valid), 1);
         chk("bp hold data", 32'(out_data), 32'h0018);
         chk("bp hold id", 32'(out_id), 0);
         chk("bp hold ready", 32'(req_ready), 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1 chk("bp hs ready", 32'(req_ready), 0);
      @(negedge clk);
      #1 chk("bp pulse1", 32'(req_ready), 32'b0010);
      chk("bp valid drop", 32'(out_valid), 0);
      @(negedge clk);
      req_valid = '0;
      #1 chk("bp conv2", 32'(req_ready), 0);
      @(negedge clk);
      #1 chk("bp res1 valid", 32'(out_valid), 1);
      chk("bp res1 id", 32'(out_id), 1);
      chk("bp res1 data", 32'(out_data), 32'h0020);
      @(negedge clk);

      // Async reset during HOLD
      @(negedge clk);
      rd[0] = 32'h40400000; req_valid = 4'b0001; out_ready = 1'b0;
      #1 chk("rst grant", 32'(req_ready), 32'b0001);
      @(negedge clk); req_valid = '0;
      @(negedge clk);
      #1 chk("rst hold valid", 32'(out_valid), 1);
      chk("rst hold data", 32'(out_data), 32'h0030);
      #1 rst_n = 1'b0;
      #1 chk("rst async valid", 32'(out_valid), 0);
      chk("rst async busy", 32'(busy), 0);
      chk("rst async data", 32'(out_data), 0);
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rd[0] = 32'h3FC00000; rd[1] = 32'h40000000; req_valid = 4'b0011;
      #1 chk("rst first grant", 32'(req_ready), 32'b0001);
      @(negedge clk); req_valid = '0;
      @(negedge clk);
      #1 chk("rst res valid", 32'(out_valid), 1);
      chk("rst res id", 32'(out_id), 0);
      @(negedge clk);

      // Randomized traffic against the reference model
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; req_valid = '0;
      exp_q.delete();
      g = N_REQ - 1; acc = -1; nres = 0;
      for (int c = 0; c < 420; c++) begin
         int last;
         @(negedge clk);
         if (acc >= 0) begin req_valid[acc] = 1'b0; acc = -1; end
         if (c < 400) begin
            for (int i = 0; i < N_REQ; i++) begin
               if (!req_valid[i]) begin
                  if ($urandom_range(0, 2) == 0) begin req_valid[i] = 1'b1; rd[i] = rand_float(); end
               end else if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            req_valid = '0; out_ready = 1'b1;
         end
         #1;
         if (req_ready != '0) begin
            last = g;
            g = rr_pick(last, req_valid);
            chk("rand grant", 32'(req_ready), (g < 0) ? 0 : 32'(1 << g));
            if (g < 0) g = last;
            else begin
               ref_conv(rd[g], ed, es);
               r.d = ed; r.id = ID_W'(g); r.s = es;
               exp_q.push_back(r);
            end
            acc = low_bit(req_ready);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rand unexpected result: got id %0d expected none", out_id);
            end else begin
               r = exp_q.pop_front();
               chk("rand data", 32'(out_data), 32'(r.d));
               chk("rand id", 32'(out_id), 32'(r.id));
               chk("rand sat", 32'(out_sat), 32'(r.s));
               nres++;
            end
         end
      end
      chk("rand drained", exp_q.size(), 0);
      checks++;
      if (nres < 40) begin
         errors++;
         $display("FAIL rand result count: got %0d required at least 40", nres);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1, "timeout");
   end
endmodule
